cci_test_mmio_initiator: RTL and testbench
==========================================

CCI_TEST_MMIO_INITIATOR -- requirements
Module: cci_test_mmio_initiator

Interface
REQ-001 SHALL have parameter MAX_OUTSTANDING, default 4: number of read TID slots, range 1..16.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024: read response timeout in cycles, minimum 2.
REQ-003 SHALL have port clk, input, 1: the single clock; all logic is clocked on its rising edge.
REQ-004 SHALL have port reset, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have port cmd_valid, input, 1: a command is offered.
REQ-006 SHALL have port cmd_ready, output, 1: a command is accepted when cmd_valid and cmd_ready are both high.
REQ-007 SHALL have port cmd_is_write, input, 1: 1 = 64-bit write, 0 = 64-bit read.
REQ-008 SHALL have port cmd_addr, input, 16: MMIO address in 4-byte units; bit 0 is ignored and driven 0 on output.
REQ-009 SHALL have port cmd_data, input, 64: write data.
REQ-010 SHALL have ports mmio_rd_valid and mmio_wr_valid, output, 1 each: one-cycle request strobes toward the CSR responder.
REQ-011 SHALL have port mmio_addr, output, 16; port mmio_tid, output, 9; port mmio_data, output, 64; port mmio_length, output, 2 (constant 2'b01 = 8 bytes).
REQ-012 SHALL have ports rsp_valid (input, 1), rsp_tid (input, 9) and rsp_data (input, 64): read responses (mmioRdValid).
REQ-013 SHALL have ports rd_data_valid (output, 1), rd_data (output, 64) and rd_tag (output, 4): completed read, tagged with its slot index.
REQ-014 SHALL have ports rd_timeout (output, 1, pulse) and timeout_tag (output, 4).
REQ-015 SHALL have ports err_unexpected_tid (output, 1, sticky) and outstanding (output, 5, count of busy slots).

Function
REQ-016 SHALL keep a busy bitmap of MAX_OUTSTANDING slots; a read is assigned the lowest free slot index, and that index is issued as mmio_tid, zero-extended.
REQ-017 SHALL drive cmd_ready = !reset && (outstanding < MAX_OUTSTANDING), computed from registered state only; this applies to both reads and writes.
REQ-018 SHALL register the request: a command accepted in cycle N drives mmio_*_valid, mmio_addr, mmio_data and mmio_tid in cycle N+1, with exactly one strobe high.
REQ-019 SHALL treat writes as fire-and-forget: a write allocates no slot and leaves mmio_tid = 0.
REQ-020 SHALL, when rsp_valid is high in cycle M with a rsp_tid that indexes a busy slot, pulse rd_data_valid in cycle M+1 with rd_data = rsp_data and rd_tag = the slot index, and free the slot at the M+1 edge.
REQ-021 SHALL, when rsp_tid >= MAX_OUTSTANDING or indexes a free slot, drop the response, set err_unexpected_tid until reset, and leave rd_data_valid low.
REQ-022 SHALL not make a slot freed in cycle M reusable before cycle M+1; allocation and free in the same cycle update outstanding by the net change.
REQ-023 SHALL saturate the outstanding count and must never wrap; at full, cmd_ready is 0.
REQ-024 SHALL hold rd_data, rd_tag and timeout_tag at their last value when their strobes are low.

Reset
REQ-025 SHALL, while reset is asserted, immediately force every slot free, outstanding = 0, all strobes = 0, all data/tid/tag outputs = 0, err_unexpected_tid = 0 and cmd_ready = 0.
REQ-026 SHALL, on reset asserted mid-operation, discard pending reads without any rd_data_valid or rd_timeout; a later response carrying an old TID sets err_unexpected_tid.
REQ-027 SHALL raise cmd_ready in the first cycle after reset deasserts.

Configuration
REQ-028 SHALL, with macro CCI_TEST_MMIO_INITIATOR_TIMEOUT_EN defined, keep a per-slot counter that loads 0 on allocation and increments each cycle while the slot is busy.
REQ-029 SHALL, with that macro defined, when a counter reaches TIMEOUT_CYCLES-1, pulse rd_timeout with timeout_tag = the slot index on the next cycle and free the slot; the lowest index wins when several slots expire together, and the others stay busy and fire in later cycles.
REQ-030 SHALL give a matching response precedence over a timeout of the same slot in the same cycle: rd_data_valid fires and rd_timeout does not.
REQ-031 SHALL, without that macro, instantiate no counters and tie rd_timeout and timeout_tag to 0; slots are freed only by responses.

Verification
REQ-032 SHALL cover: read addr 0x0010 accepted in cycle 5 -> mmio_rd_valid=1, mmio_addr=0x0010, mmio_tid=0 in cycle 6; rsp_tid=0, data 0xDEAD in cycle 9 -> rd_data_valid with rd_tag=0, rd_data=0xDEAD in cycle 10.
REQ-033 SHALL cover: 4 back-to-back reads with no responses -> tids 0,1,2,3 issued, outstanding=4, cmd_ready=0; response to tid 2 -> next read is issued with tid 2.
REQ-034 SHALL cover: write addr 0x0040 with data 0x1234_5678 -> single mmio_wr_valid, mmio_data=0x1234_5678, outstanding unchanged.
REQ-035 SHALL cover: rsp_tid=7 with nothing outstanding -> err_unexpected_tid=1 and no rd_data_valid.
REQ-036 SHALL cover, with TIMEOUT_EN and TIMEOUT_CYCLES=8: read on tid 0 with no response -> rd_timeout with timeout_tag=0 eight cycles after issue, then outstanding=0.
REQ-037 SHALL cover: reset asserted with 3 reads outstanding -> outputs 0 immediately; a later rsp_tid=1 -> err_unexpected_tid=1.

Source files
------------

// File: rtl/cci_test_mmio_initiator.sv
// MMIO read/write initiator toward a CCI CSR responder.
// Reads take the lowest free TID slot (0..MAX_OUTSTANDING-1) and hold it
// until a matching response arrives; writes are fire-and-forget.
// Optional per-slot read timeout: define CCI_TEST_MMIO_INITIATOR_TIMEOUT_EN.
//
// Handshake: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both high; cmd_ready depends only on reset and registered
// slot state, never on cmd_valid. Responses have no backpressure.
module cci_test_mmio_initiator #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_is_write,
  input  logic [15:0] cmd_addr,
  input  logic [63:0] cmd_data,
  output logic        mmio_rd_valid,
  output logic        mmio_wr_valid,
  output logic [15:0] mmio_addr,
  output logic [8:0]  mmio_tid,
  output logic [63:0] mmio_data,
  output logic [1:0]  mmio_length,
  input  logic        rsp_valid,
  input  logic [8:0]  rsp_tid,
  input  logic [63:0] rsp_data,
  output logic        rd_data_valid,
  output logic [63:0] rd_data,
  output logic [3:0]  rd_tag,
  output logic        rd_timeout,
  output logic [3:0]  timeout_tag,
  output logic        err_unexpected_tid,
  output logic [4:0]  outstanding
);

  localparam int N = MAX_OUTSTANDING;

  logic [N-1:0] busy;
  logic [N-1:0] alloc_mask;
  logic [N-1:0] rsp_mask;
  logic [N-1:0] to_mask;
  logic [3:0]   free_idx;
  logic [3:0]   rsp_idx;
  logic         rsp_hit;
  logic         rsp_bad;
  logic         accept;
  logic         alloc;
  logic         unused_ok;

  assign mmio_length = 2'b01;
  assign accept      = cmd_valid && cmd_ready;
  assign alloc       = accept && !cmd_is_write;
  assign cmd_ready   = !reset && (outstanding < 5'(N));

  // Count of busy slots; can never exceed N, so it cannot wrap.
  always_comb begin
    outstanding = '0;
    for (int i = 0; i < N; i++) begin
      outstanding = outstanding + 5'(busy[i]);
    end
  end

  // Lowest free slot and its one-hot allocation mask.
  always_comb begin
    free_idx   = '0;
    alloc_mask = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!busy[i]) free_idx = 4'(i);
    end
    for (int i = 0; i < N; i++) begin
      if (alloc && (free_idx == 4'(i))) alloc_mask[i] = 1'b1;
    end
  end

  // Match the response TID against busy slots; anything else is unexpected.
  always_comb begin
    rsp_mask = '0;
    rsp_idx  = '0;
    rsp_hit  = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (rsp_valid && busy[i] && (rsp_tid == 9'(i))) begin
        rsp_mask[i] = 1'b1;
        rsp_idx     = 4'(i);
        rsp_hit     = 1'b1;
      end
    end
    rsp_bad = rsp_valid && !rsp_hit;
  end

`ifdef CCI_TEST_MMIO_INITIATOR_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt [N];
  logic [N-1:0]  exp_mask;
  logic [3:0]    to_idx;
  logic          to_hit;

  // Expired slots, excluding any slot answered this cycle; lowest wins.
  always_comb begin
    exp_mask = '0;
    to_mask  = '0;
    to_idx   = '0;
    to_hit   = 1'b0;
    for (int i = 0; i < N; i++) begin
      exp_mask[i] = busy[i] && (cnt[i] == CNT_LAST) && !rsp_mask[i];
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (exp_mask[i]) begin
        to_idx = 4'(i);
        to_hit = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (to_hit && (to_idx == 4'(i))) to_mask[i] = 1'b1;
    end
  end

  // Per-slot age counters; saturate so a losing expired slot fires later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (alloc_mask[i])                      cnt[i] <= '0;
        else if (busy[i] && (cnt[i] != CNT_LAST)) cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end

  // Timeout pulse and held tag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_timeout  <= 1'b0;
      timeout_tag <= '0;
    end else begin
      rd_timeout <= to_hit;
      if (to_hit) timeout_tag <= to_idx;
    end
  end

  assign unused_ok = cmd_addr[0];
`else
  assign to_mask     = '0;
  assign rd_timeout  = 1'b0;
  assign timeout_tag = '0;
  assign unused_ok   = cmd_addr[0] ^ (TIMEOUT_CYCLES == 0);
`endif

  // Slot bitmap: frees come from registered busy, so a slot freed this
  // cycle is only allocatable from the next cycle on.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) busy <= '0;
    else       busy <= (busy & ~rsp_mask & ~to_mask) | alloc_mask;
  end

  // Registered request toward the CSR responder.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mmio_rd_valid <= 1'b0;
      mmio_wr_valid <= 1'b0;
      mmio_addr     <= '0;
      mmio_tid      <= '0;
      mmio_data     <= '0;
    end else begin
      mmio_rd_valid <= accept && !cmd_is_write;
      mmio_wr_valid <= accept && cmd_is_write;
      if (accept) begin
        mmio_addr <= {cmd_addr[15:1], 1'b0};
        mmio_data <= cmd_data;
        mmio_tid  <= cmd_is_write ? 9'd0 : {5'd0, free_idx};
      end
    end
  end

  // Read completion, held data/tag, sticky unexpected-TID flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data_valid      <= 1'b0;
      rd_data            <= '0;
      rd_tag             <= '0;
      err_unexpected_tid <= 1'b0;
    end else begin
      rd_data_valid <= rsp_hit;
      if (rsp_hit) begin
        rd_data <= rsp_data;
        rd_tag  <= rsp_idx;
      end
      if (rsp_bad) err_unexpected_tid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cci_test_mmio_initiator.sv
// Directed bench for cci_test_mmio_initiator (MAX_OUTSTANDING = 4).
module tb_cci_test_mmio_initiator;

`ifdef CCI_TEST_MMIO_INITIATOR_TIMEOUT_EN
  localparam int TO_CYC = 8;
`else
  localparam int TO_CYC = 1024;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_is_write = 1'b0;
  logic [15:0] cmd_addr = '0;
  logic [63:0] cmd_data = '0;
  logic        mmio_rd_valid, mmio_wr_valid;
  logic [15:0] mmio_addr;
  logic [8:0]  mmio_tid;
  logic [63:0] mmio_data;
  logic [1:0]  mmio_length;
  logic        rsp_valid = 1'b0;
  logic [8:0]  rsp_tid = '0;
  logic [63:0] rsp_data = '0;
  logic        rd_data_valid;
  logic [63:0] rd_data;
  logic [3:0]  rd_tag;
  logic        rd_timeout;
  logic [3:0]  timeout_tag;
  logic        err_unexpected_tid;
  logic [4:0]  outstanding;

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] exp_q[$];

  cci_test_mmio_initiator #(.MAX_OUTSTANDING(4), .TIMEOUT_CYCLES(TO_CYC)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_is_write(cmd_is_write),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .mmio_rd_valid(mmio_rd_valid), .mmio_wr_valid(mmio_wr_valid),
    .mmio_addr(mmio_addr), .mmio_tid(mmio_tid), .mmio_data(mmio_data),
    .mmio_length(mmio_length),
    .rsp_valid(rsp_valid), .rsp_tid(rsp_tid), .rsp_data(rsp_data),
    .rd_data_valid(rd_data_valid), .rd_data(rd_data), .rd_tag(rd_tag),
    .rd_timeout(rd_timeout), .timeout_tag(timeout_tag),
    .err_unexpected_tid(err_unexpected_tid), .outstanding(outstanding)
  );

  // Clock.
  always #5 clk = ~clk;

  // Advance one rising edge, then sample 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_cmd(input logic wr, input logic [15:0] addr, input logic [63:0] data);
    cmd_valid    = 1'b1;
    cmd_is_write = wr;
    cmd_addr     = addr;
    cmd_data     = data;
  endtask

  task automatic idle_cmd();
    cmd_valid = 1'b0;
  endtask

  task automatic drive_rsp(input logic [8:0] tid, input logic [63:0] data);
    rsp_valid = 1'b1;
    rsp_tid   = tid;
    rsp_data  = data;
  endtask

  task automatic idle_rsp();
    rsp_valid = 1'b0;
  endtask

  // Pop the scoreboard and check the read completion just sampled.
  task automatic chk_rd(input string tag, input logic [3:0] exp_tag);
    logic [63:0] e;
    chk({tag, "_valid"}, 64'(rd_data_valid), 64'd1);
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL %s_queue: observed empty expected entry", tag);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_data"}, rd_data, e);
    end
    chk({tag, "_tag"}, 64'(rd_tag), 64'(exp_tag));
  endtask

  initial begin
    logic [8:0] order [4];
    // Reset state.
    #2;
    chk("rst_ready", 64'(cmd_ready), 64'd0);
    tick(); tick();
    chk("rst_outstanding", 64'(outstanding), 64'd0);
    chk("rst_rd_valid", 64'(mmio_rd_valid), 64'd0);
    chk("rst_err", 64'(err_unexpected_tid), 64'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_ready", 64'(cmd_ready), 64'd1);
    tick();

    // Single read, addr bit 0 ignored.
    drive_cmd(1'b0, 16'h0011, 64'h0);
    tick();
    idle_cmd();
    chk("rd1_strobe", 64'(mmio_rd_valid), 64'd1);
    chk("rd1_wr_strobe", 64'(mmio_wr_valid), 64'd0);
    chk("rd1_addr", 64'(mmio_addr), 64'h0010);
    chk("rd1_tid", 64'(mmio_tid), 64'd0);
    chk("rd1_length", 64'(mmio_length), 64'd1);
    chk("rd1_outstanding", 64'(outstanding), 64'd1);
    tick(); tick();
    chk("rd1_strobe_drop", 64'(mmio_rd_valid), 64'd0);
    drive_rsp(9'd0, 64'hDEAD);
    exp_q.push_back(64'hDEAD);
    tick();
    idle_rsp();
    chk_rd("rd1", 4'd0);
    chk("rd1_free", 64'(outstanding), 64'd0);
    tick();
    chk("rd1_valid_drop", 64'(rd_data_valid), 64'd0);
    chk("rd1_data_hold", rd_data, 64'hDEAD);

    // Four back-to-back reads fill every slot.
    for (int i = 0; i < 4; i++) begin
      drive_cmd(1'b0, 16'h0100 + 16'(i * 2), 64'h0);
      chk($sformatf("fill_ready_%0d", i), 64'(cmd_ready), 64'd1);
      tick();
      chk($sformatf("fill_tid_%0d", i), 64'(mmio_tid), 64'(i));
    end
    chk("full_outstanding", 64'(outstanding), 64'd4);
    chk("full_ready", 64'(cmd_ready), 64'd0);
    tick();
    chk("full_no_issue", 64'(mmio_rd_valid), 64'd0);
    idle_cmd();
    drive_rsp(9'd2, 64'h22);
    exp_q.push_back(64'h22);
    tick();
    idle_rsp();
    chk_rd("rsp2", 4'd2);
    chk("rsp2_outstanding", 64'(outstanding), 64'd3);
    chk("rsp2_ready", 64'(cmd_ready), 64'd1);
    drive_cmd(1'b0, 16'h0200, 64'h0);
    tick();
    idle_cmd();
    chk("reuse_tid", 64'(mmio_tid), 64'd2);
    chk("reuse_outstanding", 64'(outstanding), 64'd4);
    order[0] = 9'd0; order[1] = 9'd1; order[2] = 9'd3; order[3] = 9'd2;
    for (int i = 0; i < 4; i++) begin
      drive_rsp(order[i], 64'h100 + 64'(order[i]));
      exp_q.push_back(64'h100 + 64'(order[i]));
      tick();
      chk_rd($sformatf("drain_%0d", i), order[i][3:0]);
    end
    idle_rsp();
    chk("drain_outstanding", 64'(outstanding), 64'd0);

    // Write: single strobe, no slot.
    drive_cmd(1'b1, 16'h0040, 64'h1234_5678);
    tick();
    idle_cmd();
    chk("wr_strobe", 64'(mmio_wr_valid), 64'd1);
    chk("wr_rd_strobe", 64'(mmio_rd_valid), 64'd0);
    chk("wr_addr", 64'(mmio_addr), 64'h0040);
    chk("wr_data", mmio_data, 64'h1234_5678);
    chk("wr_tid", 64'(mmio_tid), 64'd0);
    chk("wr_outstanding", 64'(outstanding), 64'd0);
    tick();
    chk("wr_strobe_drop", 64'(mmio_wr_valid), 64'd0);

    // Free and allocate in the same cycle: net change zero, freed slot not reused.
    drive_cmd(1'b0, 16'h0300, 64'h0);
    tick();
    drive_rsp(9'd0, 64'hA0);
    exp_q.push_back(64'hA0);
    tick();
    idle_cmd();
    idle_rsp();
    chk("net_tid", 64'(mmio_tid), 64'd1);
    chk("net_outstanding", 64'(outstanding), 64'd1);
    chk_rd("net_rsp", 4'd0);
    drive_rsp(9'd1, 64'hA1);
    exp_q.push_back(64'hA1);
    tick();
    idle_rsp();
    chk_rd("net_rsp1", 4'd1);

    // Unexpected TID.
    drive_rsp(9'd7, 64'hBAD);
    tick();
    idle_rsp();
    chk("unexp_err", 64'(err_unexpected_tid), 64'd1);
    chk("unexp_no_valid", 64'(rd_data_valid), 64'd0);
    tick();
    chk("unexp_sticky", 64'(err_unexpected_tid), 64'd1);
    chk("unexp_data_hold", rd_data, 64'hA1);

`ifdef CCI_TEST_MMIO_INITIATOR_TIMEOUT_EN
    // Timeout eight cycles after issue.
    drive_cmd(1'b0, 16'h0400, 64'h0);
    tick();
    idle_cmd();
    chk("to_issue_tid", 64'(mmio_tid), 64'd0);
    for (int i = 1; i < 8; i++) begin
      tick();
      chk($sformatf("to_quiet_%0d", i), 64'(rd_timeout), 64'd0);
    end
    tick();
    chk("to_pulse", 64'(rd_timeout), 64'd1);
    chk("to_tag", 64'(timeout_tag), 64'd0);
    chk("to_outstanding", 64'(outstanding), 64'd0);
    chk("to_no_data", 64'(rd_data_valid), 64'd0);
    tick();
    chk("to_pulse_drop", 64'(rd_timeout), 64'd0);

    // Response in the expiry cycle wins.
    drive_cmd(1'b0, 16'h0410, 64'h0);
    tick();
    idle_cmd();
    for (int i = 0; i < 7; i++) tick();
    drive_rsp(9'd0, 64'hC0);
    exp_q.push_back(64'hC0);
    tick();
    idle_rsp();
    chk_rd("prec", 4'd0);
    chk("prec_no_timeout", 64'(rd_timeout), 64'd0);
    tick();
    chk("prec_no_late_timeout", 64'(rd_timeout), 64'd0);
    chk("prec_outstanding", 64'(outstanding), 64'd0);
`else
    // No timeout logic: a read stays outstanding indefinitely.
    drive_cmd(1'b0, 16'h0400, 64'h0);
    tick();
    idle_cmd();
    for (int i = 0; i < 20; i++) tick();
    chk("nto_timeout", 64'(rd_timeout), 64'd0);
    chk("nto_outstanding", 64'(outstanding), 64'd1);
    drive_rsp(9'd0, 64'hC0);
    exp_q.push_back(64'hC0);
    tick();
    idle_rsp();
    chk_rd("nto_rsp", 4'd0);
`endif

    // Reset with three reads outstanding.
    for (int i = 0; i < 3; i++) begin
      drive_cmd(1'b0, 16'h0500 + 16'(i * 2), 64'h0);
      tick();
    end
    idle_cmd();
    chk("prerst_outstanding", 64'(outstanding), 64'd3);
    reset = 1'b1;
    #1;
    chk("mid_rst_outstanding", 64'(outstanding), 64'd0);
    chk("mid_rst_ready", 64'(cmd_ready), 64'd0);
    chk("mid_rst_rd_valid", 64'(mmio_rd_valid), 64'd0);
    chk("mid_rst_tid", 64'(mmio_tid), 64'd0);
    chk("mid_rst_err", 64'(err_unexpected_tid), 64'd0);
    chk("mid_rst_rd_data", rd_data, 64'd0);
    chk("mid_rst_addr", 64'(mmio_addr), 64'd0);
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("rel_ready", 64'(cmd_ready), 64'd1);
    drive_rsp(9'd1, 64'hEE);
    tick();
    idle_rsp();
    chk("stale_err", 64'(err_unexpected_tid), 64'd1);
    chk("stale_no_valid", 64'(rd_data_valid), 64'd0);
    chk("stale_no_timeout", 64'(rd_timeout), 64'd0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
